apb_fsm_controller: RTL
=======================

Name: apb_fsm_controller

Overview:
- APB-side state machine of the AHB-to-APB bridge, sitting directly upstream of the APB output interface.
- Converts qualified AHB transfers from the AHB slave interface into APB setup/enable sequences: Pwrite, Penable, Pselx, Paddr, Pwdata.
- Stalls the AHB master through Hreadyout while the APB transfer is in progress.
- Non-pipelined: one AHB transfer in flight at a time.

Parameters:
ADDR_WIDTH, 32, width of Haddr/Paddr
DATA_WIDTH, 32, width of Hwdata/Pwdata
SEL_WIDTH, 3, number of APB peripheral selects (one-hot)

Ports:
Hclk  input  1  bridge clock; all state changes on rising edge
Hresetn  input  1  asynchronous active-low reset
valid  input  1  qualified AHB address phase present this cycle (HSEL, NONSEQ/SEQ, Hreadyin)
Hwrite  input  1  direction of the current address phase (1 = write)
Haddr  input  ADDR_WIDTH  current AHB address-phase address
Hwdata  input  DATA_WIDTH  AHB write data (valid in the data phase)
tempselx  input  SEL_WIDTH  one-hot peripheral select decoded from Haddr
Pwrite  output  1  APB direction, registered
Penable  output  1  APB enable, registered
Pselx  output  SEL_WIDTH  APB select, registered
Paddr  output  ADDR_WIDTH  APB address, registered
Pwdata  output  DATA_WIDTH  APB write data, registered
Hreadyout  output  1  ready back to AHB, registered

Behaviour:
- All outputs are registered and updated on the edge that enters a state; state is a one-hot or binary encoded register.
- Reset (Hresetn=0, asynchronous, any state, including mid-transfer):
  - state -> IDLE.
  - Pwrite=0, Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1.
  - Any transfer in progress is abandoned.
- Accept condition: valid=1 and tempselx!=0, sampled only in IDLE, RENABLE or WENABLE. When Hreadyout=0, valid is ignored.
- IDLE: Hreadyout=1, Penable=0, Pselx=0; Paddr, Pwdata and Pwrite hold their last values.
  - accept & !Hwrite -> READ
  - accept & Hwrite -> WWAIT
  - otherwise stay in IDLE.
- Entry to READ:
  - Paddr<=Haddr, Pselx<=tempselx, Pwrite<=0, Penable<=0, Hreadyout<=0.
  - Next state: RENABLE, unconditionally.
- Entry to RENABLE:
  - Penable<=1, Hreadyout<=1; Paddr, Pselx and Pwrite hold.
  - The downstream read data is valid in this cycle.
- Entry to WWAIT:
  - Hreadyout<=0, which extends the AHB write data phase so Hwdata stays stable.
  - Internal addr_hold<=Haddr, sel_hold<=tempselx.
  - APB outputs: Penable=0, Pselx=0.
  - Next state: WRITE, unconditionally.
- Entry to WRITE:
  - Paddr<=addr_hold, Pselx<=sel_hold, Pwdata<=Hwdata (sampled at the WWAIT->WRITE edge), Pwrite<=1, Penable<=0, Hreadyout<=0.
  - Next state: WENABLE.
- Entry to WENABLE: Penable<=1, Hreadyout<=1; Paddr, Pwdata, Pselx and Pwrite hold.
- Exit from RENABLE or WENABLE (same decision as IDLE):
  - accept & !Hwrite -> READ (back-to-back, no IDLE cycle)
  - accept & Hwrite -> WWAIT
  - else -> IDLE, with Penable<=0 and Pselx<=0.
- Latency:
  - Read: accepted address phase -> Penable=1 after 2 edges; AHB sees 1 wait state.
  - Write: accepted address phase -> Penable=1 after 3 edges; AHB sees 2 wait states.
- Invariants:
  - Penable=1 only in RENABLE or WENABLE, always preceded by exactly one setup cycle with the same Paddr and Pselx.
  - Pselx is one-hot or zero.
  - Pwdata changes only on entry to WRITE.
  - No illegal-state lockup: unused encodings -> IDLE.
- Widths: straight copies, no arithmetic; Paddr is the full ADDR_WIDTH with no truncation.

Test Plan:
- Reset: Hresetn low mid-WRITE (Paddr=0x8000_0010) -> immediately Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1, and state IDLE after release.
- Single read: valid=1, Hwrite=0, Haddr=0x8000_0004, tempselx=3'b001 in IDLE -> next edge Paddr=0x8000_0004, Pselx=001, Pwrite=0, Penable=0, Hreadyout=0; following edge Penable=1, Hreadyout=1; then IDLE with Pselx=0.
- Single write: Haddr=0x8400_0008, tempselx=010, Hwdata=0xDEAD_BEEF in the data phase -> WWAIT (Hreadyout=0), WRITE (Paddr=0x8400_0008, Pwdata=0xDEAD_BEEF, Pwrite=1, Penable=0), WENABLE (Penable=1, Hreadyout=1).
- Back-to-back: read 0x8000_0000 followed by write 0x8000_0020/0x1234_5678 with valid held in RENABLE -> RENABLE goes directly to WWAIT with no IDLE cycle; Paddr sequence 0x8000_0000 then 0x8000_0020.
- Ignore while busy: valid=1 with Haddr=0x8800_0000 pulsed during READ and WWAIT (Hreadyout=0) -> no state change, Paddr unaffected.
- Invalid select: valid=1, tempselx=000 in IDLE -> stays IDLE; Pselx=0, Penable=0, Hreadyout=1.

Source files
------------

// File: rtl/apb_fsm_controller.sv
// APB-side FSM of the AHB-to-APB bridge.
// Turns accepted AHB transfers into APB setup/enable sequences.
module apb_fsm_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  valid,
  input  logic                  Hwrite,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic [SEL_WIDTH-1:0]  tempselx,
  output logic                  Pwrite,
  output logic                  Penable,
  output logic [SEL_WIDTH-1:0]  Pselx,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic [DATA_WIDTH-1:0] Pwdata,
  output logic                  Hreadyout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_RENABLE = 3'd2,
    S_WWAIT   = 3'd3,
    S_WRITE   = 3'd4,
    S_WENABLE = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                  accept;
  logic                  pwrite_d;
  logic                  penable_d;
  logic [SEL_WIDTH-1:0]  pselx_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  hready_d;
  logic [ADDR_WIDTH-1:0] addr_hold, addr_hold_d;
  logic [SEL_WIDTH-1:0]  sel_hold, sel_hold_d;

  assign accept = valid & (|tempselx);

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= S_IDLE;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Pselx     <= '0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
      addr_hold <= '0;
      sel_hold  <= '0;
    end else begin
      state_q   <= state_d;
      Pwrite    <= pwrite_d;
      Penable   <= penable_d;
      Pselx     <= pselx_d;
      Paddr     <= paddr_d;
      Pwdata    <= pwdata_d;
      Hreadyout <= hready_d;
      addr_hold <= addr_hold_d;
      sel_hold  <= sel_hold_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE, S_RENABLE, S_WENABLE: begin
        if (accept)
          state_d = Hwrite ? S_WWAIT : S_READ;
        else
          state_d = S_IDLE;
      end
      S_READ:  state_d = S_RENABLE;
      S_WWAIT: state_d = S_WRITE;
      S_WRITE: state_d = S_WENABLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the state being entered on the next edge.
  always_comb begin
    pwrite_d    = Pwrite;
    penable_d   = Penable;
    pselx_d     = Pselx;
    paddr_d     = Paddr;
    pwdata_d    = Pwdata;
    hready_d    = Hreadyout;
    addr_hold_d = addr_hold;
    sel_hold_d  = sel_hold;
    unique case (state_d)
      S_READ: begin
        paddr_d   = Haddr;
        pselx_d   = tempselx;
        pwrite_d  = 1'b0;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      S_RENABLE, S_WENABLE: begin
        penable_d = 1'b1;
        hready_d  = 1'b1;
      end
      S_WWAIT: begin
        penable_d   = 1'b0;
        pselx_d     = '0;
        hready_d    = 1'b0;
        addr_hold_d = Haddr;
        sel_hold_d  = tempselx;
      end
      S_WRITE: begin
        paddr_d   = addr_hold;
        pselx_d   = sel_hold;
        pwdata_d  = Hwdata;
        pwrite_d  = 1'b1;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end
      default: begin
        penable_d = 1'b0;
        pselx_d   = '0;
        hready_d  = 1'b1;
      end
    endcase
  end

endmodule
